// File: rtl/data_memory_arbiter_pkg.sv
// Shared types and constants for the DataMemory arbiter slice.
package data_memory_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_DEPTH      = 32;

    localparam logic PORT_CORE   = 1'b0;
    localparam logic PORT_LOADER = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester-side bundle of the DataMemory arbiter: two request/grant/response ports.
interface data_memory_arbiter_if
    import data_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);

    logic                  req0,   req1;
    logic                  we0,    we1;
    logic [ADDR_WIDTH-1:0] addr0,  addr1;
    logic [DATA_WIDTH-1:0] wdata0, wdata1;
    logic                  gnt0,   gnt1;
    logic                  rvalid0, rvalid1;
    logic [DATA_WIDTH-1:0] rdata0, rdata1;
    logic                  err0,   err1;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, err0, err1
    );

endinterface

// File: rtl/data_memory_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module rr_arbiter2 (
    input  logic req0,
    input  logic req1,
    input  logic lastGrant,
    output logic grantId,
    output logic grantValid
);

    always_comb begin
        grantValid = req0 | req1;
        if (req0 && req1) begin
            grantId = ~lastGrant;
        end else begin
            grantId = req1;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Round-robin sharing of single-port DataMemory between core (port 0) and loader (port 1).
// Optional address range check enabled by defining DMARB_BOUNDS_CHECK_EN.
module data_memory_arbiter
    import data_memory_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    data_memory_arbiter_if.slave  bus,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memWrite,
    output logic                  memRead,
    input  logic [DATA_WIDTH-1:0] memReadData
);

`ifdef DMARB_BOUNDS_CHECK_EN
    localparam logic BOUNDS_EN = 1'b1;
`else
    localparam logic BOUNDS_EN = 1'b0;
`endif

    localparam logic [ADDR_WIDTH-1:0] DEPTH_LIMIT = ADDR_WIDTH'(DEPTH);

    state_t                state;
    logic                  last_grant;
    logic                  owner;
    logic                  cmd_we;
    logic                  cmd_oob;
    logic                  grant_id;
    logic                  grant_valid;
    logic                  sel_we;
    logic                  sel_oob;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    rr_arbiter2 u_rr (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .lastGrant  (last_grant),
        .grantId    (grant_id),
        .grantValid (grant_valid)
    );

    always_comb begin
        sel_we    = (grant_id == PORT_LOADER) ? bus.we1    : bus.we0;
        sel_addr  = (grant_id == PORT_LOADER) ? bus.addr1  : bus.addr0;
        sel_wdata = (grant_id == PORT_LOADER) ? bus.wdata1 : bus.wdata0;
        sel_oob   = BOUNDS_EN && (sel_addr >= DEPTH_LIMIT);
    end

    // Memory strobes are registered at capture so they are live exactly for the ACCESS cycle
    // and fall asynchronously with reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            last_grant   <= PORT_LOADER;
            owner        <= PORT_CORE;
            cmd_we       <= 1'b0;
            cmd_oob      <= 1'b0;
            memAddress   <= '0;
            memWriteData <= '0;
            memWrite     <= 1'b0;
            memRead      <= 1'b0;
            bus.gnt0     <= 1'b0;
            bus.gnt1     <= 1'b0;
            bus.rvalid0  <= 1'b0;
            bus.rvalid1  <= 1'b0;
            bus.err0     <= 1'b0;
            bus.err1     <= 1'b0;
            bus.rdata0   <= '0;
            bus.rdata1   <= '0;
        end else begin
            bus.gnt0    <= 1'b0;
            bus.gnt1    <= 1'b0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.err0    <= 1'b0;
            bus.err1    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner        <= grant_id;
                        last_grant   <= grant_id;
                        cmd_we       <= sel_we;
                        cmd_oob      <= sel_oob;
                        memAddress   <= sel_addr;
                        memWriteData <= sel_wdata;
                        memWrite     <= sel_we && !sel_oob;
                        memRead      <= !sel_we && !sel_oob;
                        bus.gnt0     <= (grant_id == PORT_CORE);
                        bus.gnt1     <= (grant_id == PORT_LOADER);
                        state        <= ACCESS;
                    end
                end
                ACCESS: begin
                    memAddress   <= '0;
                    memWriteData <= '0;
                    memWrite     <= 1'b0;
                    memRead      <= 1'b0;
                    if (owner == PORT_CORE) begin
                        bus.rvalid0 <= 1'b1;
                        bus.err0    <= cmd_oob;
                        if (!cmd_we) bus.rdata0 <= cmd_oob ? '0 : memReadData;
                    end else begin
                        bus.rvalid1 <= 1'b1;
                        bus.err1    <= cmd_oob;
                        if (!cmd_we) bus.rdata1 <= cmd_oob ? '0 : memReadData;
                    end
                    state <= RESP;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed plus randomized bench for data_memory_arbiter against a word-array memory model.
module tb_data_memory_arbiter;
    import data_memory_pkg::*;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 32;
`ifdef DMARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memWriteData;
    logic [DW-1:0] memReadData;
    logic          memWrite;
    logic          memRead;

    always #5 clock = ~clock;

    data_memory_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus_if),
        .memAddress   (memAddress),
        .memWriteData (memWriteData),
        .memWrite     (memWrite),
        .memRead      (memRead),
        .memReadData  (memReadData)
    );

    // DataMemory stand-in: combinational read, write on rising edge, out-of-range reads give a tag
    logic [DW-1:0] mem_array [DEPTH];
    logic [DW-1:0] model_mem [DEPTH];

    always @(posedge clock)
        if (memWrite && memAddress < DEPTH) mem_array[memAddress[4:0]] <= memWriteData;

    assign memReadData = (memAddress < DEPTH) ? mem_array[memAddress[4:0]]
                                              : (32'hBAD0_0000 | memAddress);

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int strobes = 0;

    always @(negedge clock) begin
        if (reset) begin
            if ((bus_if.gnt0 && bus_if.gnt1) || (bus_if.rvalid0 && bus_if.rvalid1) ||
                (memWrite && memRead))
                viol++;
        end
        if (memWrite || memRead) strobes++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int p, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus_if.req0 = r; bus_if.we0 = w; bus_if.addr0 = a; bus_if.wdata0 = d;
        end else begin
            bus_if.req1 = r; bus_if.we1 = w; bus_if.addr1 = a; bus_if.wdata1 = d;
        end
    endtask

    task automatic set_req(input int p, input logic r);
        if (p == 0) bus_if.req0 = r;
        else        bus_if.req1 = r;
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 0) ? bus_if.gnt0 : bus_if.gnt1;
    endfunction

    function automatic logic rvalid_of(input int p);
        return (p == 0) ? bus_if.rvalid0 : bus_if.rvalid1;
    endfunction

    function automatic logic err_of(input int p);
        return (p == 0) ? bus_if.err0 : bus_if.err1;
    endfunction

    function automatic logic [31:0] rdata_of(input int p);
        return (p == 0) ? bus_if.rdata0 : bus_if.rdata1;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] addr);
        if (addr < DEPTH) return model_mem[addr[4:0]];
        return BOUNDS ? 32'h0 : (32'hBAD0_0000 | addr);
    endfunction

    // One complete transaction on port p; exp_wait = negedges from request to grant (-1: skip)
    task automatic access(input int p, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input bit keep, input int exp_wait,
                          input string tag);
        int waited;
        int other_gnt;
        bit got;
        bit oob;
        oob       = BOUNDS && (addr >= DEPTH);
        waited    = 0;
        other_gnt = 0;
        got       = 1'b0;
        drive(p, 1'b1, we, addr, wd);
        while (!got && waited < 20) begin
            @(negedge clock);
            waited++;
            if (gnt_of(1 - p)) other_gnt++;
            got = gnt_of(p);
        end
        chk({tag, ":gnt"}, 32'(got), 32'd1);
        if (!got) begin
            set_req(p, 1'b0);
            return;
        end
        if (exp_wait >= 0) chk({tag, ":gnt_wait"}, 32'(waited), 32'(exp_wait));
        chk({tag, ":other_gnt"}, 32'(other_gnt), 32'd0);
        chk({tag, ":memWrite"}, 32'(memWrite), 32'(we && !oob));
        chk({tag, ":memRead"},  32'(memRead),  32'(!we && !oob));
        chk({tag, ":memAddress"}, memAddress, addr);
        if (we) chk({tag, ":memWriteData"}, memWriteData, wd);
        if (!keep) set_req(p, 1'b0);
        @(negedge clock);
        chk({tag, ":rvalid"}, 32'(rvalid_of(p)), 32'd1);
        chk({tag, ":other_rvalid"}, 32'(rvalid_of(1 - p)), 32'd0);
        chk({tag, ":err"}, 32'(err_of(p)), 32'(oob));
        chk({tag, ":mem_idle"}, 32'(memWrite || memRead), 32'd0);
        if (!we) chk({tag, ":rdata"}, rdata_of(p), exp_read(addr));
        if (we && addr < DEPTH) model_mem[addr[4:0]] = wd;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ":gnt"},    32'({bus_if.gnt0, bus_if.gnt1}), 32'd0);
        chk({tag, ":rvalid"}, 32'({bus_if.rvalid0, bus_if.rvalid1}), 32'd0);
        chk({tag, ":err"},    32'({bus_if.err0, bus_if.err1}), 32'd0);
        chk({tag, ":rdata0"}, bus_if.rdata0, 32'd0);
        chk({tag, ":rdata1"}, bus_if.rdata1, 32'd0);
        chk({tag, ":mem_strobe"}, 32'({memWrite, memRead}), 32'd0);
        chk({tag, ":memAddress"}, memAddress, 32'd0);
    endtask

    task automatic gap();
        repeat (2) @(negedge clock);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] old7;
        int s0;
        int rv;
        int waited;
        bit got;

        for (int i = 0; i < int'(DEPTH); i++) begin
            v = $urandom;
            mem_array[i] = v;
            model_mem[i] = v;
        end
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);

        // reset state, then idle with no requests
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("t1_in_reset");
        reset = 1'b1;
        s0 = strobes;
        repeat (4) @(negedge clock);
        check_all_zero("t1_idle");
        chk("t1_no_strobes", 32'(strobes - s0), 32'd0);

        // write then read back across ports
        access(0, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 1, "t2_wr");
        access(1, 1'b0, 32'd5, 32'd0,        1'b0, 2, "t2_rd");
        chk("t2_rdata1", bus_if.rdata1, 32'hDEADBEEF);

        for (int k = 0; k < 8; k++) begin
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   32'($urandom_range(0, DEPTH - 1)), $urandom, 1'b0, 2, "rand");
        end

        // fairness: both held from a fresh reset, port 0 first then alternating
        gap();
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        drive(1, 1'b1, 1'b0, 32'd9, 32'd0);
        for (int k = 0; k < 6; k++) begin
            access(k % 2, 1'($urandom_range(0, 1)), 32'($urandom_range(0, DEPTH - 1)),
                   $urandom, (k < 5), (k == 0) ? 1 : 2, "t3_rr");
        end
        set_req(0, 1'b0);

        // reset during the ACCESS cycle of a write aborts it
        gap();
        old7 = $urandom;
        access(0, 1'b1, 32'd7, old7, 1'b0, 1, "t4_pre");
        gap();
        drive(0, 1'b1, 1'b1, 32'd7, ~old7);
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 20) begin
            @(negedge clock);
            waited++;
            got = bus_if.gnt0;
        end
        chk("t4_gnt0", 32'(got), 32'd1);
        chk("t4_memWrite_before", 32'(memWrite), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("t4_memWrite_async", 32'(memWrite), 32'd0);
        chk("t4_memAddress_async", memAddress, 32'd0);
        set_req(0, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        rv = 0;
        repeat (4) begin
            @(negedge clock);
            if (bus_if.rvalid0 || bus_if.rvalid1) rv++;
        end
        chk("t4_no_rvalid", 32'(rv), 32'd0);
        chk("t4_mem7_kept", mem_array[7], old7);
        access(1, 1'b0, 32'd7, 32'd0, 1'b0, 1, "t4_rd");
        chk("t4_rdata1", bus_if.rdata1, old7);

        // loader alone, four back-to-back reads
        for (int i = 0; i < 4; i++) begin
            access(1, 1'b0, 32'(i), 32'd0, (i < 3), (i == 0) ? 2 : 2, "t6_burst");
        end

        // out-of-range read
        gap();
        access(0, 1'b0, 32'd40, 32'd0, 1'b0, 1, "t5_oob");
        chk("t5_err0", 32'(bus_if.err0), 32'(BOUNDS));

        gap();
        chk("exclusive", 32'(viol), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
